// File: rtl/cylon_input_ctrl.sv
// Input conditioning ahead of the cylon LED sequencer: two-flop synchronisers on the
// buttons and low switch nibble, a four-state debouncer per button, and the
// registered mode, speed and brightness controls with their pulse/strobe outputs.
module cylon_input_ctrl #(
  parameter int unsigned       CNT_W           = 20,
  parameter logic [CNT_W-1:0]  DEBOUNCE_CYCLES = CNT_W'(1_000_000)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btnC,
  input  logic        btnL,
  input  logic        btnR,
  input  logic [15:0] sw,
  output logic [1:0]  mode,
  output logic [3:0]  speed,
  output logic [3:0]  brightness,
  output logic [2:0]  btn_pulse,
  output logic        mode_changed
);

  // Final count value at which a level is considered stable.
  localparam logic [CNT_W-1:0] LastCount = DEBOUNCE_CYCLES - CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StArm, StHeld, StDisarm} db_state_e;

  // Bit order matches btn_pulse: {L, C, R}.
  logic [2:0] btn_raw;
  logic [2:0] btn_meta;
  logic [2:0] btn_sync;
  logic [3:0] sw_meta;
  logic [3:0] sw_sync;
  logic [2:0] pulse;
  logic [1:0] mode_next;

  // Only sw[3:0] is consumed; the rest of the bank is deliberately ignored.
  logic unused_sw;
  assign unused_sw = ^sw[15:4];

  assign btn_raw   = {btnL, btnC, btnR};
  assign btn_pulse = pulse;

  // Two-flop synchronisers; nothing downstream looks at a raw input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      sw_meta  <= sw[3:0];
      sw_sync  <= sw_meta;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : gen_db
    db_state_e        state;
    logic [CNT_W-1:0] count;

    // Debounce FSM: counter is cleared on every transition so it can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= StIdle;
        count    <= '0;
        pulse[i] <= 1'b0;
      end else begin
        pulse[i] <= 1'b0;
        case (state)
          StIdle: begin
            if (btn_sync[i]) begin
              state <= StArm;
              count <= '0;
            end
          end
          StArm: begin
            if (!btn_sync[i]) begin
              state <= StIdle;
              count <= '0;
            end else if (count == LastCount) begin
              state    <= StHeld;
              count    <= '0;
              pulse[i] <= 1'b1;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
          StHeld: begin
            if (!btn_sync[i]) begin
              state <= StDisarm;
              count <= '0;
            end
          end
          StDisarm: begin
            // A bounce back high returns to HELD without a second pulse.
            if (btn_sync[i]) begin
              state <= StHeld;
              count <= '0;
            end else if (count == LastCount) begin
              state <= StIdle;
              count <= '0;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
          default: begin
            state <= StIdle;
            count <= '0;
          end
        endcase
      end
    end
  end

  // Mode select with priority C > R > L; no pulse holds the current mode.
  always_comb begin
    mode_next = mode;
    if (pulse[1]) begin
      mode_next = 2'b00;
    end else if (pulse[0]) begin
      mode_next = 2'b10;
    end else if (pulse[2]) begin
      mode_next = 2'b01;
    end
  end

  // Mode register; the strobe fires only when the value actually changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode         <= 2'b00;
      mode_changed <= 1'b0;
    end else begin
      mode         <= mode_next;
      mode_changed <= (mode_next != mode);
    end
  end

  // Switch-derived controls, registered every cycle with no debounce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed      <= 4'h0;
      brightness <= 4'b0111;
    end else begin
      speed      <= {1'b0, sw_sync[2:0]};
      brightness <= {sw_sync[3], 3'b111};
    end
  end

endmodule

// File: tb/tb_cylon_input_ctrl.sv
// Scoreboard bench for cylon_input_ctrl with a 4-cycle debounce.
module tb_cylon_input_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btnC = 1'b0;
  logic        btnL = 1'b0;
  logic        btnR = 1'b0;
  logic [15:0] sw = 16'h0;
  logic [1:0]  mode;
  logic [3:0]  speed;
  logic [3:0]  brightness;
  logic [2:0]  btn_pulse;
  logic        mode_changed;

  cylon_input_ctrl #(
    .CNT_W          (20),
    .DEBOUNCE_CYCLES(20'd4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btnC        (btnC),
    .btnL        (btnL),
    .btnR        (btnR),
    .sw          (sw),
    .mode        (mode),
    .speed       (speed),
    .brightness  (brightness),
    .btn_pulse   (btn_pulse),
    .mode_changed(mode_changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [2:0] pulse;
    logic [1:0] mode;
    logic       chg;
  } btn_exp_t;

  typedef struct {
    int         at;
    logic [3:0] speed;
    logic [3:0] bright;
  } sw_exp_t;

  btn_exp_t bq[$];
  sw_exp_t  sq[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Step to just after the next rising edge; inputs driven here are first sampled one edge later.
  task automatic next_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_edges(input int n);
    for (int i = 0; i < n; i++) next_edge();
  endtask

  task automatic push_btn(input int at, input logic [2:0] p, input logic [1:0] m, input logic c);
    btn_exp_t e;
    e.at = at; e.pulse = p; e.mode = m; e.chg = c;
    bq.push_back(e);
  endtask

  task automatic push_sw(input int at, input logic [3:0] s, input logic [3:0] b);
    sw_exp_t e;
    e.at = at; e.speed = s; e.bright = b;
    sq.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: checks every output once per cycle on the falling edge.
  initial begin
    logic [1:0] exp_mode;
    logic [2:0] exp_pulse;
    logic       exp_chg;
    logic [3:0] exp_speed;
    logic [3:0] exp_bright;
    logic       pend;
    logic [1:0] pend_mode;
    logic       pend_chg;
    btn_exp_t   be;
    sw_exp_t    se;
    exp_mode = 2'b00; exp_speed = 4'h0; exp_bright = 4'b0111; pend = 1'b0;
    pend_mode = 2'b00; pend_chg = 1'b0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (!rst_n) begin
        pend = 1'b0;
        exp_mode = 2'b00; exp_speed = 4'h0; exp_bright = 4'b0111;
        check("rst_mode", 32'(mode), 32'(2'b00));
        check("rst_speed", 32'(speed), 32'h0);
        check("rst_bright", 32'(brightness), 32'h7);
        check("rst_pulse", 32'(btn_pulse), 32'h0);
        check("rst_chg", 32'(mode_changed), 32'h0);
      end else begin
        exp_chg = 1'b0;
        if (pend) begin
          exp_mode = pend_mode;
          exp_chg  = pend_chg;
          pend     = 1'b0;
        end
        exp_pulse = 3'b000;
        while (bq.size() > 0 && bq[0].at < cyc) begin
          be = bq.pop_front();
          check("pulse_missed", 32'(cyc), 32'(be.at));
        end
        if (bq.size() > 0 && bq[0].at == cyc) begin
          be        = bq.pop_front();
          exp_pulse = be.pulse;
          pend      = 1'b1;
          pend_mode = be.mode;
          pend_chg  = be.chg;
        end
        if (sq.size() > 0 && sq[0].at <= cyc) begin
          se = sq.pop_front();
          check("sw_edge", 32'(cyc), 32'(se.at));
          exp_speed  = se.speed;
          exp_bright = se.bright;
        end
        check("btn_pulse", 32'(btn_pulse), 32'(exp_pulse));
        check("mode", 32'(mode), 32'(exp_mode));
        check("mode_changed", 32'(mode_changed), 32'(exp_chg));
        check("speed", 32'(speed), 32'(exp_speed));
        check("brightness", 32'(brightness), 32'(exp_bright));
      end
    end
  end

  initial begin
    // 1: reset, then idle
    wait_edges(3);
    rst_n = 1'b1;
    wait_edges(20);

    // 2: btnR held; pulse 7 edges after the driving edge, mode 10 one edge later
    btnR = 1'b1;
    push_btn(cyc + 7, 3'b001, 2'b10, 1'b1);
    wait_edges(100);
    btnR = 1'b0;
    wait_edges(12);

    // 3: btnL glitches (3 high, 1 low, 3 high) never pulse; then a real 10-cycle press
    btnL = 1'b1; wait_edges(3);
    btnL = 1'b0; wait_edges(1);
    btnL = 1'b1; wait_edges(3);
    btnL = 1'b0; wait_edges(8);
    btnL = 1'b1;
    push_btn(cyc + 7, 3'b100, 2'b01, 1'b1);
    wait_edges(10);
    btnL = 1'b0;
    wait_edges(12);

    // 4: back to 10, then C+L together -> 00, then C again -> no strobe
    btnR = 1'b1;
    push_btn(cyc + 7, 3'b001, 2'b10, 1'b1);
    wait_edges(10);
    btnR = 1'b0;
    wait_edges(12);
    btnC = 1'b1; btnL = 1'b1;
    push_btn(cyc + 7, 3'b110, 2'b00, 1'b1);
    wait_edges(10);
    btnC = 1'b0; btnL = 1'b0;
    wait_edges(12);
    btnC = 1'b1;
    push_btn(cyc + 7, 3'b010, 2'b00, 1'b0);
    wait_edges(10);
    btnC = 1'b0;
    wait_edges(12);

    // 5: switches, upper bits must be ignored
    sw = 16'hA5AD;
    push_sw(cyc + 3, 4'b0101, 4'b1111);
    wait_edges(6);
    sw = 16'hFFF0;
    push_sw(cyc + 3, 4'b0000, 4'b0111);
    wait_edges(6);
    sw = 16'h0000;
    wait_edges(4);

    // 6: reset while btnR sits in ARM at count 2, fresh debounce after release
    btnR = 1'b1;
    wait_edges(5);
    rst_n = 1'b0;
    wait_edges(2);
    rst_n = 1'b1;
    push_btn(cyc + 7, 3'b001, 2'b10, 1'b1);
    wait_edges(15);
    btnR = 1'b0;
    wait_edges(12);

    check("btn_queue_drained", 32'(bq.size()), 32'd0);
    check("sw_queue_drained", 32'(sq.size()), 32'd0);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case anything stalls.
  initial begin
    #200000;
    $display("FAIL timeout: edge %0d reached without completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cylon_input_ctrl.md
Name: cylon_input_ctrl

Overview:
Front-end conditioning stage directly upstream of the cylon LED sequencer on the board top level. Synchronises and debounces the three raw push-buttons and the switch bank, then produces the registered mode, speed and brightness controls the sequencer consumes. Also emits single-cycle press pulses and a mode-change strobe.

Parameters:
DEBOUNCE_CYCLES, 20'd1_000_000, cycles a synchronised button level must hold before acceptance; 10 ms at 100 MHz; legal range 2..2^CNT_W-1.
CNT_W, 20, width of each debounce counter.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
btnC  input  1  raw centre button, active high, asynchronous to clk
btnL  input  1  raw left button, active high, asynchronous
btnR  input  1  raw right button, active high, asynchronous
sw  input  16  raw slide switches, asynchronous; only sw[3:0] used
mode  output  2  00 = cylon, 01 = right-to-left, 10 = left-to-right; 11 never driven
speed  output  4  {1'b0, sw[2:0]} after synchronisation
brightness  output  4  {sw[3], 3'b111} after synchronisation
btn_pulse  output  3  {L, C, R} one-cycle debounced press pulses
mode_changed  output  1  one-cycle strobe, coincident with the cycle mode takes a new value

Behaviour:
- Reset (rst_n low, asynchronous): all sync flops 0, all debounce FSMs in IDLE, counters 0; mode = 2'b00, speed = 4'h0, brightness = 4'b0111, btn_pulse = 3'b000, mode_changed = 0.
- Synchronisers: every button and sw[3:0] pass through a 2-flop synchroniser. Nothing downstream samples a raw input.
- Per-button debounce FSM, four states, counter cleared on every state entry:
  - IDLE: sync = 1 -> ARM.
  - ARM: sync = 0 -> IDLE. Otherwise count++. When count == DEBOUNCE_CYCLES-1 and sync = 1 -> HELD, and that button's btn_pulse bit is registered high for exactly one cycle.
  - HELD: sync = 0 -> DISARM. No repeated pulses while held.
  - DISARM: sync = 1 -> HELD with no pulse. Otherwise count++. When count == DEBOUNCE_CYCLES-1 -> IDLE.
- Press latency: raw level high and stable from edge k gives btn_pulse high during the cycle after edge k+DEBOUNCE_CYCLES+2.
- Glitch rejection: any synchronised low pulse during ARM restarts debouncing from IDLE. A pulse shorter than DEBOUNCE_CYCLES never produces btn_pulse.
- Mode register, updated on the edge after a btn_pulse:
  - C -> 00, R -> 10, L -> 01.
  - Simultaneous pulses use priority C > R > L.
  - No pulse -> hold.
- mode_changed goes high in the same cycle mode updates, only if the new value differs from the old one. Re-pressing the current mode gives no strobe.
- speed and brightness are registered from the synchronised switches every cycle, 3-edge latency from raw. No debounce; switch bounce passes through and is tolerated by the sequencer.
- Reset mid-debounce: the counter is discarded. After release, a still-held button needs a full fresh debounce and then produces a pulse, because the FSM restarts in IDLE.
- Counter never wraps: it is compared with == and cleared on every transition. CNT_W must satisfy DEBOUNCE_CYCLES < 2^CNT_W.

Test Plan:
(Bench uses DEBOUNCE_CYCLES = 4.)
1. Reset release, no inputs -> mode = 00, speed = 0, brightness = 0111, btn_pulse = 000, mode_changed = 0 indefinitely.
2. btnR held high from edge 10 -> btn_pulse = 001 only in the cycle after edge 16; mode = 10 and mode_changed = 1 in the cycle after edge 17; both stay quiet while btnR is held 100 cycles.
3. btnL pulses high for 3 cycles, low for 1, high for 3 -> no btn_pulse, mode unchanged. Then held for 10 cycles -> exactly one pulse, mode = 01.
4. btnC and btnL rise on the same edge from mode = 10 -> both pulse bits set together, mode = 00, one mode_changed strobe. Repeat btnC press -> btn_pulse C fires, mode_changed stays 0.
5. sw[3:0] = 4'b1101 -> speed = 0101, brightness = 1111 three edges later. sw[3:0] = 0 -> speed = 0000, brightness = 0111.
6. rst_n asserted while btnR is in ARM at count 2 -> outputs return to reset values immediately. btnR still held after release -> one pulse after a full 4-cycle debounce plus sync latency.
